// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution result path.
//   W      pixel width, equal to the output FIFO data width
//   PACK   pixels packed into one bus word
//   CNT_W  width of the per-run pixel count
//   BUS_W  packed word width (W*PACK)
//   rd_state_t  states of the output FIFO reader
package conv_pkg;

  localparam int W     = 8;
  localparam int PACK  = 4;
  localparam int CNT_W = 20;
  localparam int BUS_W = W * PACK;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND,
    DONE
  } rd_state_t;

endpackage

// File: rtl/output_fifo_reader.sv
// Drains convolution result pixels from the output FIFO, packs PACK pixels
// per bus word and presents the words on a valid/ready stream.
// Ports:
//   clk, rstn        system clock, synchronous active-low reset
//   start            one-cycle pulse beginning a run (ignored while busy)
//   total_count      pixels to drain, sampled on start
//   fifo_rd_en       read strobe to the output FIFO
//   fifo_rd_data     FIFO data, valid the cycle after fifo_rd_en
//   fifo_empty       FIFO empty flag
//   fifo_wr_en       producer write strobe into the same FIFO
//   m_data           packed word, pixel 0 in the low lane
//   m_keep           thermometer lane-valid mask
//   m_last           final word of the run
//   m_valid/m_ready  output stream handshake
//   busy             run in progress
//   done             one-cycle pulse after the last word is accepted
module output_fifo_reader
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CNT_W-1:0] total_count,
  output logic             fifo_rd_en,
  input  logic [W-1:0]     fifo_rd_data,
  input  logic             fifo_empty,
  input  logic             fifo_wr_en,
  output logic [BUS_W-1:0] m_data,
  output logic [PACK-1:0]  m_keep,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PACK - 1);

  rd_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [BUS_W-1:0]  word_reg, word_next;
  logic [PACK-1:0]   keep_reg, keep_next;

  // The FIFO silently drops a read that collides with a write, so the
  // strobe is held off whenever the producer is writing.
  assign fifo_rd_en = (state_reg == FETCH) && !fifo_empty && !fifo_wr_en;

  assign m_data  = word_reg;
  assign m_keep  = keep_reg;
  assign m_valid = (state_reg == SEND);
  assign m_last  = (state_reg == SEND) && (remaining_reg == '0);
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    lane_next      = lane_reg;
    word_next      = word_reg;
    keep_next      = keep_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (total_count == '0) begin
            state_next = DONE;
          end else begin
            remaining_next = total_count;
            lane_next      = '0;
            word_next      = '0;
            keep_next      = '0;
            state_next     = FETCH;
          end
        end
      end

      FETCH: begin
        if (fifo_rd_en) begin
          state_next = CAPTURE;
        end
      end

      CAPTURE: begin
        // Lanes fill from bit 0 upward, so keep grows as a thermometer.
        word_next[int'(lane_reg)*W +: W] = fifo_rd_data;
        keep_next[lane_reg]              = 1'b1;
        remaining_next                   = remaining_reg - 1'b1;
        if ((lane_reg == LAST_LANE) || (remaining_next == '0)) begin
          state_next = SEND;
        end else begin
          lane_next  = lane_reg + 1'b1;
          state_next = FETCH;
        end
      end

      SEND: begin
        if (m_ready) begin
          // Clearing on every handshake keeps unfilled lanes of the next
          // (possibly partial) word at zero.
          word_next  = '0;
          keep_next  = '0;
          lane_next  = '0;
          state_next = (remaining_reg == '0) ? DONE : FETCH;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      lane_reg      <= '0;
      word_reg      <= '0;
      keep_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      lane_reg      <= lane_next;
      word_reg      <= word_next;
      keep_reg      <= keep_next;
    end
  end

endmodule
